game_spawn_scheduler: RTL and testbench
=======================================

# game_spawn_scheduler

Sequences target launches for the dodge game and owns the difficulty and score state. It paces target respawns with a frame-tick cooldown and requests each launch from the master FSM through a req/ack handshake. It supplies the spawn pattern and speed that drive the target sprite's write_x/dx/dy muxing, and tracks score, lives and game-over.

## Interface
- `SPEED_MIN`, default 1: speed after reset, restart and collision.
- `SPEED_MAX`, default 7: speed saturation value.
- `TARGETS_PER_LEVEL`, default 5: dodged targets per speed step; must be ≥1.
- `COOLDOWN_TICKS`, default 30: frame ticks between target exit and the next spawn request; must be ≥1.
- `LIVES`, default 3: lives at start; must be ≥1.
- `SCORE_W`, default 16: score width.
- `clk` in, 1: clock.
- `rst` in, 1: reset, asynchronous, active-high.
- `start` in, 1: launch key pulse; starts or restarts a game.
- `frame_tick` in, 1: one-cycle strobe, once per frame.
- `random` in, 2: random pattern source.
- `spawn_ack` in, 1: master FSM accepted the spawn (target xy/dxy written).
- `target_exit` in, 1: pulse; active target left the screen, counts as dodged.
- `collision` in, 1: target/torpedo overlap, level or pulse.
- `spawn_req` out, 1: spawn request.
- `spawn_pattern` out, 2: entry pattern. 0 = left/down-right, 1 = right/down-left, 2 = random x/up, 3 = random x/down.
- `speed` out, 4: current target speed magnitude.
- `score` out, SCORE_W: dodged-target count.
- `lives` out, 2: remaining lives.
- `playing` out, 1: high in COOLDOWN, SPAWN_REQ and ACTIVE.
- `game_over` out, 1: high in GAME_OVER.

## Operation
- States and transitions:
  - IDLE: on `start` → COOLDOWN.
  - COOLDOWN: counter loaded with COOLDOWN_TICKS on entry and decremented on each `frame_tick`. A `frame_tick` while the counter is 1 → SPAWN_REQ.
  - SPAWN_REQ: `spawn_req`=1 and held until `spawn_ack`. On `spawn_ack` → ACTIVE.
  - ACTIVE:
    - `target_exit` → COOLDOWN.
    - `collision` → COOLDOWN, or → GAME_OVER if `lives` reaches 0.
  - GAME_OVER: on `start` → COOLDOWN.
- `spawn_pattern` latches `random` on the COOLDOWN→SPAWN_REQ transition. It is stable for the whole request and until the next latch.
- On `target_exit` in ACTIVE:
  - `score` increments, saturating at all-ones.
  - The progress counter (0..TARGETS_PER_LEVEL-1) increments. On wrap it returns to 0 and `speed` increments if below SPEED_MAX.
- On `collision` in ACTIVE:
  - `lives` decrements.
  - `speed` returns to SPEED_MIN and the progress counter returns to 0.
  - `score` is kept.
- Collision is edge-qualified: only the cycle where `collision` rises while in ACTIVE counts. A level held high costs one life.
- `start` in COOLDOWN/GAME_OVER (restart) and in IDLE: load `score`=0, `lives`=LIVES, `speed`=SPEED_MIN, progress=0.
- `start` in SPAWN_REQ/ACTIVE is ignored.
- Ignored inputs:
  - `spawn_ack` outside SPAWN_REQ.
  - `target_exit` and `collision` outside ACTIVE.
  - `frame_tick` outside COOLDOWN.

## Timing
- All outputs are registered. An input event sampled at edge N is visible after edge N.
- Reset values: state IDLE, `spawn_req` 0, `spawn_pattern` 0, `speed` SPEED_MIN, `score` 0, `lives` LIVES, `playing` 0, `game_over` 0, cooldown 0, progress 0.
- `rst` mid-operation: all of the above take effect immediately (asynchronous), including dropping `spawn_req`.
- `spawn_req` rises one cycle after the qualifying `frame_tick`. It falls the cycle after `spawn_ack` is sampled high. If `spawn_ack` is already high when `spawn_req` rises, the request lasts exactly 1 cycle.
- Simultaneous `target_exit` and collision edge in ACTIVE: collision wins; `score` and progress are unchanged.
- Simultaneous `start` and `frame_tick` in COOLDOWN: restart wins and the cooldown reloads.
- Score increment and speed step happen in the same cycle.
- `speed` never exceeds SPEED_MAX and never goes below SPEED_MIN.
- `lives` is never decremented below 0.
- `lives` reaches 0 → `game_over`=1 and `playing`=0 on the next cycle. No further `spawn_req` until `start`.

## Test plan
- Reset values: assert `rst` → all outputs at reset values. Release, idle 100 cycles without `start` → `spawn_req` stays 0, `playing` 0.
- Cooldown and handshake: COOLDOWN_TICKS=4, `frame_tick` every 10 cycles, pulse `start`.
  - `spawn_req` rises 1 cycle after the 4th tick.
  - Hold ack low 3 cycles while toggling `random` → `spawn_pattern` stays stable.
  - Assert ack → `spawn_req` 0 next cycle.
- Speed ramp: 5 spawn/exit rounds → `score` 5, `speed` 2. 40 rounds total → `speed` 7 from round 30 onward, `score` 40.
- Collision priority: `target_exit` and `collision` rise in the same cycle at `score` 7, `speed` 2 → `lives` 2, `score` 7, `speed` 1. Collision then held high 50 cycles → no further life loss.
- Game over and restart: 3 collisions → `game_over` 1, `playing` 0, no `spawn_req` over 10 frames. `start` → `score` 0, `lives` 3, `speed` 1, `game_over` 0, COOLDOWN resumes.
- Async reset mid-request: assert `rst` mid-cycle during SPAWN_REQ → `spawn_req` 0 before the next clock edge. All outputs return to reset values.

Source files
------------

// File: rtl/game_spawn_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | game_spawn_if : spawn scheduler <-> game datapath / master FSM bundle   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
interface game_spawn_if #(
  parameter int SCORE_W = 16
) ();
  logic               start;
  logic               frame_tick;
  logic [1:0]         random;
  logic               spawn_ack;
  logic               target_exit;
  logic               collision;
  logic               spawn_req;
  logic [1:0]         spawn_pattern;
  logic [3:0]         speed;
  logic [SCORE_W-1:0] score;
  logic [1:0]         lives;
  logic               playing;
  logic               game_over;

  // Scheduler side: it issues the spawn request, so it is the master.
  modport master (
    input  start, frame_tick, random, spawn_ack, target_exit, collision,
    output spawn_req, spawn_pattern, speed, score, lives, playing, game_over
  );

  modport slave (
    output start, frame_tick, random, spawn_ack, target_exit, collision,
    input  spawn_req, spawn_pattern, speed, score, lives, playing, game_over
  );
endinterface
`default_nettype wire

// File: rtl/game_spawn_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | game_spawn_scheduler : target launch pacing, difficulty, score, lives   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module game_spawn_scheduler #(
  parameter int SPEED_MIN         = 1,
  parameter int SPEED_MAX         = 7,
  parameter int TARGETS_PER_LEVEL = 5,
  parameter int COOLDOWN_TICKS    = 30,
  parameter int LIVES             = 3,
  parameter int SCORE_W           = 16
) (
  input  wire logic   clk,
  input  wire logic   rst,
  game_spawn_if.master bus
);

  localparam int c_CW = $clog2(COOLDOWN_TICKS + 1);
  localparam int c_PW = (TARGETS_PER_LEVEL > 1) ? $clog2(TARGETS_PER_LEVEL) : 1;

  localparam logic [c_CW-1:0]    c_COOL_LOAD = c_CW'(COOLDOWN_TICKS);
  localparam logic [c_PW-1:0]    c_PROG_LAST = c_PW'(TARGETS_PER_LEVEL - 1);
  localparam logic [3:0]         c_SPD_MIN   = 4'(SPEED_MIN);
  localparam logic [3:0]         c_SPD_MAX   = 4'(SPEED_MAX);
  localparam logic [1:0]         c_LIVES     = 2'(LIVES);
  localparam logic [SCORE_W-1:0] c_SCORE_SAT = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COOLDOWN  = 3'd1,
    S_SPAWN_REQ = 3'd2,
    S_ACTIVE    = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_CW-1:0]    r_cool;
  logic [c_PW-1:0]    r_prog;
  logic [1:0]         r_pattern;
  logic [3:0]         r_speed;
  logic [SCORE_W-1:0] r_score;
  logic [1:0]         r_lives;
  logic               r_coll_d;
  logic               r_spawn_req;
  logic               r_playing;
  logic               r_game_over;

  state_t             w_state_nxt;
  logic [c_CW-1:0]    w_cool_nxt;
  logic [c_PW-1:0]    w_prog_nxt;
  logic [1:0]         w_pattern_nxt;
  logic [3:0]         w_speed_nxt;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [1:0]         w_lives_nxt;
  logic               w_coll_rise;

  assign w_coll_rise = bus.collision & ~r_coll_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cool      <= '0;
      r_prog      <= '0;
      r_pattern   <= 2'd0;
      r_speed     <= c_SPD_MIN;
      r_score     <= '0;
      r_lives     <= c_LIVES;
      r_coll_d    <= 1'b0;
      r_spawn_req <= 1'b0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cool      <= w_cool_nxt;
      r_prog      <= w_prog_nxt;
      r_pattern   <= w_pattern_nxt;
      r_speed     <= w_speed_nxt;
      r_score     <= w_score_nxt;
      r_lives     <= w_lives_nxt;
      r_coll_d    <= bus.collision;
      // Status flags follow the next state so they are registered yet in step.
      r_spawn_req <= (w_state_nxt == S_SPAWN_REQ);
      r_playing   <= (w_state_nxt == S_COOLDOWN) || (w_state_nxt == S_SPAWN_REQ) ||
                     (w_state_nxt == S_ACTIVE);
      r_game_over <= (w_state_nxt == S_GAME_OVER);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cool_nxt    = r_cool;
    w_prog_nxt    = r_prog;
    w_pattern_nxt = r_pattern;
    w_speed_nxt   = r_speed;
    w_score_nxt   = r_score;
    w_lives_nxt   = r_lives;

    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (bus.start) begin
          w_state_nxt = S_COOLDOWN;
          w_cool_nxt  = c_COOL_LOAD;
          w_prog_nxt  = '0;
          w_speed_nxt = c_SPD_MIN;
          w_score_nxt = '0;
          w_lives_nxt = c_LIVES;
        end
      end

      S_COOLDOWN: begin
        if (bus.start) begin
          w_cool_nxt  = c_COOL_LOAD;
          w_prog_nxt  = '0;
          w_speed_nxt = c_SPD_MIN;
          w_score_nxt = '0;
          w_lives_nxt = c_LIVES;
        end else if (bus.frame_tick) begin
          w_cool_nxt = r_cool - 1'b1;
          if (r_cool == c_CW'(1)) begin
            w_state_nxt   = S_SPAWN_REQ;
            w_pattern_nxt = bus.random;
          end
        end
      end

      S_SPAWN_REQ: begin
        if (bus.spawn_ack) begin
          w_state_nxt = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        // A collision edge outranks a simultaneous exit: the target was hit.
        if (w_coll_rise) begin
          w_lives_nxt = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
          w_speed_nxt = c_SPD_MIN;
          w_prog_nxt  = '0;
          if (r_lives <= 2'd1) begin
            w_state_nxt = S_GAME_OVER;
          end else begin
            w_state_nxt = S_COOLDOWN;
            w_cool_nxt  = c_COOL_LOAD;
          end
        end else if (bus.target_exit) begin
          w_state_nxt = S_COOLDOWN;
          w_cool_nxt  = c_COOL_LOAD;
          if (r_score != c_SCORE_SAT) begin
            w_score_nxt = r_score + SCORE_W'(1);
          end
          if (r_prog == c_PROG_LAST) begin
            w_prog_nxt = '0;
            if (r_speed < c_SPD_MAX) begin
              w_speed_nxt = r_speed + 4'd1;
            end
          end else begin
            w_prog_nxt = r_prog + 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.spawn_req     = r_spawn_req;
  assign bus.spawn_pattern = r_pattern;
  assign bus.speed         = r_speed;
  assign bus.score         = r_score;
  assign bus.lives         = r_lives;
  assign bus.playing       = r_playing;
  assign bus.game_over     = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_game_spawn_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_game_spawn_scheduler : directed bench with a behavioural game model  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_game_spawn_scheduler;
  localparam int TPL    = 5;
  localparam int COOL   = 4;
  localparam int NLIVES = 3;
  localparam int SMIN   = 1;
  localparam int SMAX   = 7;
  localparam int SW     = 16;
  localparam int SCORE_SAT = (1 << SW) - 1;

  localparam int P_IDLE = 0, P_COOL = 1, P_REQ = 2, P_ACT = 3, P_OVER = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  game_spawn_if #(.SCORE_W(SW)) bus ();

  game_spawn_scheduler #(
    .SPEED_MIN        (SMIN),
    .SPEED_MAX        (SMAX),
    .TARGETS_PER_LEVEL(TPL),
    .COOLDOWN_TICKS   (COOL),
    .LIVES            (NLIVES),
    .SCORE_W          (SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: phase, frames left, totals dodged; speed/score derived arithmetically.
  int m_phase   = P_IDLE;
  int m_left    = 0;
  int m_pattern = 0;
  int m_total   = 0;
  int m_streak  = 0;
  int m_lives   = NLIVES;
  bit m_cprev   = 1'b0;

  function automatic int m_speed();
    int s;
    s = SMIN + m_streak / TPL;
    return (s > SMAX) ? SMAX : s;
  endfunction

  function automatic int m_score();
    return (m_total > SCORE_SAT) ? SCORE_SAT : m_total;
  endfunction

  task automatic m_new_game();
    m_total  = 0;
    m_streak = 0;
    m_lives  = NLIVES;
    m_phase  = P_COOL;
    m_left   = COOL;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE; m_left = 0; m_pattern = 0; m_total = 0;
      m_streak = 0; m_lives = NLIVES; m_cprev = 1'b0;
    end else begin
      bit rise;
      rise    = bus.collision && !m_cprev;
      m_cprev = bus.collision;
      case (m_phase)
        P_IDLE, P_OVER: if (bus.start) m_new_game();
        P_COOL: begin
          if (bus.start) m_new_game();
          else if (bus.frame_tick) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
              m_phase   = P_REQ;
              m_pattern = int'(bus.random);
            end
          end
        end
        P_REQ: if (bus.spawn_ack) m_phase = P_ACT;
        P_ACT: begin
          if (rise) begin
            m_lives  = m_lives - 1;
            m_streak = 0;
            if (m_lives == 0) m_phase = P_OVER;
            else begin m_phase = P_COOL; m_left = COOL; end
          end else if (bus.target_exit) begin
            m_total  = m_total + 1;
            m_streak = m_streak + 1;
            m_phase  = P_COOL;
            m_left   = COOL;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("spawn_req", bus.spawn_req, m_phase == P_REQ);
      check("playing", bus.playing, (m_phase == P_COOL) || (m_phase == P_REQ) || (m_phase == P_ACT));
      check("game_over", bus.game_over, m_phase == P_OVER);
      check("spawn_pattern", bus.spawn_pattern, m_pattern);
      check("speed", bus.speed, m_speed());
      check("score", bus.score, m_score());
      check("lives", bus.lives, m_lives);
    end
  end

  // Frame tick generator: one-cycle strobe every 10 clocks while enabled.
  int n_ticks = 0;
  bit tick_en = 1'b0;
  initial begin
    int ph;
    ph = 0;
    bus.frame_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en && ph == 9) begin
        bus.frame_tick = 1'b1;
        n_ticks++;
      end else begin
        bus.frame_tick = 1'b0;
      end
      ph = (ph + 1) % 10;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 400 && bus.spawn_req !== 1'b1; k++) step();
    check("wait_spawn_req", bus.spawn_req, 1);
  endtask

  task automatic round(input bit do_exit, input bit do_coll, input bit hold_coll);
    wait_req();
    bus.spawn_ack = 1'b1;
    step();
    bus.spawn_ack = 1'b0;
    bus.target_exit = do_exit;
    if (do_coll) bus.collision = 1'b1;
    step();
    bus.target_exit = 1'b0;
    if (!hold_coll) bus.collision = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_spawn_req"}, bus.spawn_req, 0);
    check({tag, "_pattern"}, bus.spawn_pattern, 0);
    check({tag, "_speed"}, bus.speed, 1);
    check({tag, "_score"}, bus.score, 0);
    check({tag, "_lives"}, bus.lives, 3);
    check({tag, "_playing"}, bus.playing, 0);
    check({tag, "_game_over"}, bus.game_over, 0);
  endtask

  initial begin
    int base, viol;
    bus.start = 0; bus.random = 0; bus.spawn_ack = 0;
    bus.target_exit = 0; bus.collision = 0;

    #1 rst = 1'b1;
    repeat (3) step();
    check_reset_vals("rst");
    rst = 1'b0;
    viol = 0;
    repeat (100) begin
      step();
      if (bus.spawn_req !== 1'b0 || bus.playing !== 1'b0) viol++;
    end
    check("idle_quiet", viol, 0);

    // First spawn: request lands one cycle after the 4th tick; pattern held.
    tick_en = 1'b1;
    bus.random = 2'd2;
    base = n_ticks;
    pulse_start();
    for (int k = 0; k < 200 && n_ticks < base + 4; k++) step();
    check("req_before_4th_tick", bus.spawn_req, 0);
    step();
    check("req_after_4th_tick", bus.spawn_req, 1);
    check("pattern_latched", bus.spawn_pattern, 2);
    for (int i = 0; i < 3; i++) begin
      bus.random = 2'(i * 3 + 1);
      step();
      check("req_held", bus.spawn_req, 1);
      check("pattern_stable", bus.spawn_pattern, 2);
    end
    bus.spawn_ack = 1'b1;
    step();
    bus.spawn_ack = 1'b0;
    check("req_drop_after_ack", bus.spawn_req, 0);
    bus.target_exit = 1'b1;
    step();
    bus.target_exit = 1'b0;
    check("score_round1", bus.score, 1);

    // Speed ramp.
    for (int r = 2; r <= 5; r++) begin bus.random = 2'(r); round(1, 0, 0); end
    check("score_5", bus.score, 5);
    check("speed_5", bus.speed, 2);
    for (int r = 6; r <= 30; r++) begin bus.random = 2'(r); round(1, 0, 0); end
    check("speed_30", bus.speed, 7);
    for (int r = 31; r <= 40; r++) begin bus.random = 2'(r); round(1, 0, 0); end
    check("score_40", bus.score, 40);
    check("speed_40", bus.speed, 7);

    // Restart from COOLDOWN, climb to score 7, then exit+collision together.
    pulse_start();
    check("restart_score", bus.score, 0);
    check("restart_speed", bus.speed, 1);
    for (int r = 0; r < 7; r++) round(1, 0, 0);
    check("pre_coll_score", bus.score, 7);
    check("pre_coll_speed", bus.speed, 2);
    round(1, 1, 1);
    check("coll_lives", bus.lives, 2);
    check("coll_score", bus.score, 7);
    check("coll_speed", bus.speed, 1);
    repeat (50) step();
    check("held_coll_lives", bus.lives, 2);
    bus.collision = 1'b0;
    step();

    // Two more hits end the game.
    round(0, 1, 0);
    check("lives_after_2nd", bus.lives, 1);
    round(0, 1, 0);
    check("go_lives", bus.lives, 0);
    check("go_flag", bus.game_over, 1);
    check("go_playing", bus.playing, 0);
    viol = 0;
    repeat (100) begin
      step();
      if (bus.spawn_req !== 1'b0) viol++;
    end
    check("go_no_req", viol, 0);
    pulse_start();
    check("rs_score", bus.score, 0);
    check("rs_lives", bus.lives, 3);
    check("rs_speed", bus.speed, 1);
    check("rs_game_over", bus.game_over, 0);
    check("rs_playing", bus.playing, 1);

    // Asynchronous reset in the middle of a request.
    wait_req();
    #1 rst = 1'b1;
    #1 check("async_drop_req", bus.spawn_req, 0);
    check_reset_vals("async");
    step();
    rst = 1'b0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
